// File: rtl/one_hot_encoder.sv
// one_hot_encoder: binary index to one-hot vector.
//   - Combinational path: one_hot_out / range_err follow binary_in in the
//     same delta, independent of clk, rst_n and in_valid.
//   - Registered path: one_hot_q / range_err_q / out_valid, one cycle behind.
//   - Optional invariant checker, enabled by defining ONE_HOT_ENCODER_CHECK_EN.
//     Without it, check_err is tied low and no checker logic exists.
//
// Valid semantics: in_valid qualifies binary_in on a rising clk edge. Every
// qualified input is accepted, with no ready or backpressure. out_valid is
// in_valid delayed by one edge. The data registers load only on qualified
// edges and otherwise hold. out_valid is 1 for exactly one cycle per accepted
// input.
module one_hot_encoder #(
  parameter int INPUT_WIDTH  = 2,
  parameter int OUTPUT_WIDTH = 1 << INPUT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INPUT_WIDTH-1:0]  binary_in,
  input  logic                    in_valid,
  output logic [OUTPUT_WIDTH-1:0] one_hot_out,
  output logic                    range_err,
  output logic [OUTPUT_WIDTH-1:0] one_hot_q,
  output logic                    out_valid,
  output logic                    range_err_q,
  output logic                    check_err
);

  localparam int FULL_WIDTH = 1 << INPUT_WIDTH;

  // Reject illegal parameterisations at elaboration time.
  if (INPUT_WIDTH < 1 || INPUT_WIDTH > 8) begin : g_bad_in_width
    $fatal(1, "one_hot_encoder: INPUT_WIDTH=%0d outside 1..8", INPUT_WIDTH);
  end
  if (OUTPUT_WIDTH < 1 || OUTPUT_WIDTH > FULL_WIDTH) begin : g_bad_out_width
    $fatal(1, "one_hot_encoder: OUTPUT_WIDTH=%0d outside 1..%0d", OUTPUT_WIDTH, FULL_WIDTH);
  end

  // Compare at 32 bits, so an out-of-range index can never alias onto a
  // real output bit.
  logic [31:0] bin_ext;
  assign bin_ext = 32'(binary_in);

  // Each output bit is an equality decode of its own index.
  for (genvar i = 0; i < OUTPUT_WIDTH; i++) begin : g_decode
    assign one_hot_out[i] = (bin_ext == i);
  end

  // Out-of-range codes exist only when the vector is narrower than 2^INPUT_WIDTH.
  if (OUTPUT_WIDTH < FULL_WIDTH) begin : g_range
    assign range_err = (bin_ext >= OUTPUT_WIDTH);
  end else begin : g_no_range
    assign range_err = 1'b0;
  end

  // Registered path: data loads on qualified edges, valid tracks in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      one_hot_q   <= '0;
      range_err_q <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        one_hot_q   <= one_hot_out;
        range_err_q <= range_err;
      end
    end
  end

`ifdef ONE_HOT_ENCODER_CHECK_EN
  // Invariant: an in-range code gives exactly one hot bit. An out-of-range
  // code gives no hot bits.
  logic chk_bad;
  assign chk_bad = range_err ? (one_hot_out != '0)
                             : ($countones(one_hot_out) != 1);

  // Sticky flag, set on any qualified edge that breaks the invariant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_err <= 1'b0;
    end else if (in_valid && chk_bad) begin
      check_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Report the same condition in simulation.
  always @(posedge clk) begin
    if (rst_n && in_valid && chk_bad) begin
      $error("one_hot_encoder: one-hot invariant violated, binary_in=%0d one_hot_out=%b",
             binary_in, one_hot_out);
    end
  end
`endif
`else
  assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_one_hot_encoder.sv
// Self-checking bench for one_hot_encoder.
// It uses two instances: the default 2->4 encoder and a 3->5 encoder that
// has out-of-range codes. A driver pushes the expected registered response
// into exp_q. A monitor pops one entry after every rising edge and compares
// it with the registered outputs.
module tb_one_hot_encoder;

  // Expected entry layout: {valid, err4, hot4[3:0], err5, hot5[4:0]}.
  localparam int W = 12;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] bin4;
  logic [2:0] bin5;

  logic [3:0] hot4, hot4_q;
  logic       err4, err4_q, vld4, chk4;
  logic [4:0] hot5, hot5_q;
  logic       err5, err5_q, vld5, chk5;

  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  // Held reference state of the registered path.
  logic [3:0] m_hot4;
  logic [4:0] m_hot5;
  logic       m_err4, m_err5;

  one_hot_encoder #(.INPUT_WIDTH(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .binary_in(bin4), .in_valid(in_valid),
    .one_hot_out(hot4), .range_err(err4), .one_hot_q(hot4_q),
    .out_valid(vld4), .range_err_q(err4_q), .check_err(chk4)
  );

  one_hot_encoder #(.INPUT_WIDTH(3), .OUTPUT_WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .binary_in(bin5), .in_valid(in_valid),
    .one_hot_out(hot5), .range_err(err5), .one_hot_q(hot5_q),
    .out_valid(vld5), .range_err_q(err5_q), .check_err(chk5)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // Reference model: index b sets bit b when b < width. Otherwise no bit is
  // set and the range flag is raised.
  function automatic logic [31:0] ref_hot(int b, int width);
    return (b < width) ? (32'd1 << b) : 32'd0;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_hot4 = '0; m_err4 = 1'b0;
    m_hot5 = '0; m_err5 = 1'b0;
    exp_q.delete();
  endtask

  // Driver: applies one cycle of stimulus, checks the combinational outputs
  // and pushes the expected registered outputs for the next edge.
  task automatic drive(logic v, int a, int b);
    logic [31:0] h4, h5;
    @(negedge clk);
    in_valid = v;
    bin4 = 2'(a);
    bin5 = 3'(b);
    #1;
    h4 = ref_hot(a, 4);
    h5 = ref_hot(b, 5);
    check("comb hot4", 32'(hot4), h4);
    check("comb err4", 32'(err4), 32'(a >= 4));
    check("comb hot5", 32'(hot5), h5);
    check("comb err5", 32'(err5), 32'(b >= 5));
    if (v) begin
      m_hot4 = h4[3:0]; m_err4 = (a >= 4);
      m_hot5 = h5[4:0]; m_err5 = (b >= 5);
    end
    exp_q.push_back({v, m_err4, m_hot4, m_err5, m_hot5});
  endtask

  // Monitor: one pop and comparison after each rising edge.
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_valid4",  32'(vld4),   32'(e[11]));
      check("range_err_q4", 32'(err4_q), 32'(e[10]));
      check("one_hot_q4",  32'(hot4_q), 32'(e[9:6]));
      check("out_valid5",  32'(vld5),   32'(e[11]));
      check("range_err_q5", 32'(err5_q), 32'(e[5]));
      check("one_hot_q5",  32'(hot5_q), 32'(e[4:0]));
      check("check_err4",  32'(chk4),   32'd0);
      check("check_err5",  32'(chk5),   32'd0);
    end
  end

  task automatic check_regs_zero(string tag);
    check({tag, " one_hot_q4"}, 32'(hot4_q), 32'd0);
    check({tag, " out_valid4"}, 32'(vld4), 32'd0);
    check({tag, " range_err_q4"}, 32'(err4_q), 32'd0);
    check({tag, " one_hot_q5"}, 32'(hot5_q), 32'd0);
    check({tag, " out_valid5"}, 32'(vld5), 32'd0);
    check({tag, " range_err_q5"}, 32'(err5_q), 32'd0);
    check({tag, " check_err4"}, 32'(chk4), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    bin4 = '0;
    bin5 = '0;
    model_reset();

    // Combinational sweep while held in reset, 10 ns per code.
    for (int i = 0; i < 8; i++) begin
      bin4 = 2'(i);
      bin5 = 3'(i);
      #10;
      if (i < 4) begin
        check("sweep hot4", 32'(hot4), ref_hot(i, 4));
        check("sweep err4", 32'(err4), 32'd0);
      end
      check("sweep hot5", 32'(hot5), ref_hot(i, 5));
      check("sweep err5", 32'(err5), 32'(i >= 5));
    end
    check_regs_zero("reset");

    @(negedge clk);
    rst_n = 1'b1;

    // Single valid input followed by an idle cycle. Data must hold.
    drive(1'b1, 2, 4);
    drive(1'b0, 0, 6);
    drive(1'b0, 1, 0);
    // Back-to-back stream of 3, 0, 1.
    drive(1'b1, 3, 6);
    drive(1'b1, 0, 7);
    drive(1'b1, 1, 1);
    // Sweep every code with in_valid high.
    for (int i = 0; i < 8; i++) drive(1'b1, i % 4, i);

    // Randomized traffic.
    for (int n = 0; n < 300; n++)
      drive(1'(($urandom_range(0, 3) != 0)), $urandom_range(0, 3), $urandom_range(0, 7));

    // Asynchronous reset between edges while out_valid is high.
    drive(1'b1, 3, 6);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_regs_zero("async reset");
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // More random traffic after recovery.
    for (int n = 0; n < 100; n++)
      drive(1'(($urandom_range(0, 1) != 0)), $urandom_range(0, 3), $urandom_range(0, 7));

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
